fp_core_arbiter: RTL and testbench

//  Shares one pipelined float32 operator (multiply_float / Divide_float / suma_float class,

---
 rtl/fp_core_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_fp_core_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_core_arbiter.sv
// ---------------------------------------------------------------------------
// fp_core_arbiter
//
// Shares one fully pipelined, fixed-latency float32 operator among NREQ
// requesters. At most one operation is issued per cycle. Each issue is tagged
// with its requester index in a LAT-deep tag pipeline, and the tag is used to
// route the core result back to its owner.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   LAT   core latency, operation_nd -> rdy, in cycles (1..32)
//   W     operand/result width
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req          per-requester request, held with operands until its gnt
//   op_a, op_b   packed operands, requester i at [i*W +: W]
//   gnt          one-hot, one-cycle grant pulse
//   core_a/b     registered operands to the core
//   core_nd      operation_nd to the core
//   core_result  core result
//   core_rdy     core rdy
//   res          registered result
//   res_valid    one-hot, one-cycle owner strobe for res
//   busy         an operation is issued or still in flight
//   err          sticky tag/rdy mismatch flag (cleared by rst only)
//
// Build option
//   FP_ARB_PRIORITY_EN  when defined, requester 0 has strict priority and
//                       requesters 1..NREQ-1 round-robin among themselves.
//                       When undefined, plain round-robin over all requesters.
// ---------------------------------------------------------------------------
module fp_core_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 8,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      core_a,
  output logic [W-1:0]      core_b,
  output logic              core_nd,
  input  logic [W-1:0]      core_result,
  input  logic              core_rdy,
  output logic [W-1:0]      res,
  output logic [NREQ-1:0]   res_valid,
  output logic              busy,
  output logic              err
);

  localparam int IW = $clog2(NREQ);
  localparam int DW = $clog2(LAT + 1);

  // registered state
  logic [NREQ-1:0]         r_gnt;
  logic [W-1:0]            r_core_a;
  logic [W-1:0]            r_core_b;
  logic                    r_nd;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           r_rr_ptr;
  logic [LAT-1:0]          r_tag_v;
  logic [LAT-1:0][IW-1:0]  r_tag_i;
  logic [W-1:0]            r_res;
  logic [NREQ-1:0]         r_res_valid;
  logic                    r_err;
  logic [DW-1:0]           r_drain;

  // combinational
  logic [W-1:0]            w_op_a [NREQ];
  logic [W-1:0]            w_op_b [NREQ];
  logic [NREQ-1:0]         w_req_eff;
  logic                    w_found;
  logic [IW-1:0]           w_win;
  logic [IW-1:0]           w_rr_next;
  logic [NREQ-1:0]         w_win_oh;
  logic [LAT-1:0]          w_tag_v_shift;
  logic [LAT-1:0][IW-1:0]  w_tag_i_shift;
  logic                    w_tag_v_out;
  logic [IW-1:0]           w_tag_i_out;
  logic [NREQ-1:0]         w_tag_oh;
  logic                    w_rdy_eff;

  // Unpack operands and build one-hot decodes.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign w_op_a[gi]   = op_a[gi*W +: W];
    assign w_op_b[gi]   = op_b[gi*W +: W];
    assign w_win_oh[gi] = w_found && (w_win == IW'(gi));
    assign w_tag_oh[gi] = (w_tag_i_out == IW'(gi));
  end

  // A requester currently seeing its grant still has req high this cycle;
  // masking it prevents a back-to-back double issue of the same operands.
  assign w_req_eff = req & ~r_gnt;

`ifdef FP_ARB_PRIORITY_EN
  // Requester 0 wins outright; others round-robin over 1..NREQ-1.
  always_comb begin
    logic [IW:0]   v_sum;
    logic [IW-1:0] v_base;
    logic [IW-1:0] v_idx;
    w_found   = 1'b0;
    w_win     = '0;
    w_rr_next = r_rr_ptr;
    v_sum     = '0;
    v_idx     = '0;
    // rr_ptr resets to 0, which is not a member of the 1..NREQ-1 ring.
    v_base    = (r_rr_ptr == '0) ? IW'(1) : r_rr_ptr;
    if (w_req_eff[0]) begin
      w_found = 1'b1;
      w_win   = '0;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        v_sum = {1'b0, v_base} - (IW+1)'(1) + (IW+1)'(k);
        if (v_sum >= (IW+1)'(NREQ - 1)) v_sum = v_sum - (IW+1)'(NREQ - 1);
        v_idx = v_sum[IW-1:0] + IW'(1);
        if (!w_found && w_req_eff[v_idx]) begin
          w_found = 1'b1;
          w_win   = v_idx;
        end
      end
    end
    // A requester-0 grant leaves the pointer where it was.
    if (w_found && (w_win != '0))
      w_rr_next = (w_win == IW'(NREQ - 1)) ? IW'(1) : w_win + IW'(1);
  end
`else
  // Plain round-robin starting at rr_ptr.
  always_comb begin
    logic [IW:0] v_sum;
    w_found   = 1'b0;
    w_win     = '0;
    w_rr_next = r_rr_ptr;
    v_sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (v_sum >= (IW+1)'(NREQ)) v_sum = v_sum - (IW+1)'(NREQ);
      if (!w_found && w_req_eff[v_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_win   = v_sum[IW-1:0];
      end
    end
    if (w_found)
      w_rr_next = (w_win == IW'(NREQ - 1)) ? '0 : w_win + IW'(1);
  end
`endif

  // Tag pipeline: stage 0 takes the tag of the op on core_nd this cycle, so
  // the last stage lines up with the core's rdy for that op.
  if (LAT == 1) begin : g_tag_short
    assign w_tag_v_shift = r_nd;
    assign w_tag_i_shift = r_idx;
  end else begin : g_tag_long
    assign w_tag_v_shift = {r_tag_v[LAT-2:0], r_nd};
    assign w_tag_i_shift = {r_tag_i[LAT-2:0], r_idx};
  end

  assign w_tag_v_out = r_tag_v[LAT-1];
  assign w_tag_i_out = r_tag_i[LAT-1];

  // After reset the core may still return ops issued before it; the drain
  // window swallows those rdys without raising err.
  assign w_rdy_eff = core_rdy && (r_drain == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt       <= '0;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_nd        <= 1'b0;
      r_idx       <= '0;
      r_rr_ptr    <= '0;
      r_tag_v     <= '0;
      r_tag_i     <= '0;
      r_res       <= '0;
      r_res_valid <= '0;
      r_err       <= 1'b0;
      r_drain     <= DW'(LAT);
    end else begin
      // issue side
      r_gnt    <= w_win_oh;
      r_nd     <= w_found;
      r_idx    <= w_win;
      r_rr_ptr <= w_rr_next;
      if (w_found) begin
        r_core_a <= w_op_a[w_win];
        r_core_b <= w_op_b[w_win];
      end

      // tag pipeline advances every cycle
      r_tag_v <= w_tag_v_shift;
      r_tag_i <= w_tag_i_shift;

      if (r_drain != '0) r_drain <= r_drain - DW'(1);

      // return side
      r_res_valid <= '0;
      if (w_rdy_eff && w_tag_v_out) begin
        r_res       <= core_result;
        r_res_valid <= w_tag_oh;
      end else if (w_rdy_eff != w_tag_v_out) begin
        r_err <= 1'b1;
      end
    end
  end

  assign gnt       = r_gnt;
  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign core_nd   = r_nd;
  assign res       = r_res;
  assign res_valid = r_res_valid;
  assign err       = r_err;
  assign busy      = r_nd | (|r_tag_v);

endmodule

// File: tb/tb_fp_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_core_arbiter
//
// Directed bench for fp_core_arbiter (NREQ=4, LAT=8, W=32). A behavioural core
// (integer a*b, LAT-cycle pipeline, not reset by rst) answers core_nd. The
// bench can inject a spurious rdy or suppress an expected one. Expected grant
// order follows FP_ARB_PRIORITY_EN if it is defined for the build.
// ---------------------------------------------------------------------------
module tb_fp_core_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 8;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      core_a;
  logic [W-1:0]      core_b;
  logic              core_nd;
  logic [W-1:0]      core_result;
  logic              core_rdy;
  logic [W-1:0]      res;
  logic [NREQ-1:0]   res_valid;
  logic              busy;
  logic              err;

  int checks   = 0;
  int failures = 0;

  fp_core_arbiter #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .op_a        (op_a),
    .op_b        (op_b),
    .gnt         (gnt),
    .core_a      (core_a),
    .core_b      (core_b),
    .core_nd     (core_nd),
    .core_result (core_result),
    .core_rdy    (core_rdy),
    .res         (res),
    .res_valid   (res_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // behavioural core
  logic [LAT-1:0]        pv = '0;
  logic [LAT-1:0][W-1:0] pr = '0;
  logic                  inj_rdy  = 1'b0;
  logic                  drop_rdy = 1'b0;

  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], core_nd};
    pr <= {pr[LAT-2:0], core_a * core_b};
  end

  assign core_rdy    = (pv[LAT-1] & ~drop_rdy) | inj_rdy;
  assign core_result = pr[LAT-1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_nd", 64'(core_nd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (LAT) step();
  endtask

  // Wait (bounded) for a res_valid strobe; n = cycles waited.
  task automatic wait_res(input string tag, output logic [NREQ-1:0] rv,
                          output logic [W-1:0] r, output int n);
    n = 0;
    while (res_valid == '0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_to"}, 64'(n < 40), 64'd1);
    rv = res_valid;
    r  = res;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] rv;
    logic [W-1:0]    r;
    logic [NREQ-1:0] seen_v;
    logic            seen_e;
    int              n;
    int              ord[6];
    int              idx;
`ifdef FP_ARB_PRIORITY_EN
    ord = '{0, 1, 0, 2, 0, 3};
`else
    ord = '{0, 1, 2, 3, 0, 1};
`endif
    rst  = 1'b1;
    req  = '0;
    op_a = '0;
    op_b = '0;

    // reset state
    do_reset();
    chk("rst_core_a", 64'(core_a), 64'd0);
    chk("rst_res", 64'(res), 64'd0);
    chk("rst_resv", 64'(res_valid), 64'd0);

    // single op on requester 2
    set_op(2, 32'd7, 32'd9);
    req = 4'b0100;
    step();
    chk("t1_gnt", 64'(gnt), 64'h4);
    chk("t1_nd", 64'(core_nd), 64'd1);
    chk("t1_a", 64'(core_a), 64'd7);
    chk("t1_b", 64'(core_b), 64'd9);
    chk("t1_busy", 64'(busy), 64'd1);
    req = '0;
    wait_res("t1", rv, r, n);
    chk("t1_lat", 64'(n), 64'(LAT + 1));
    chk("t1_resv", 64'(rv), 64'h4);
    chk("t1_res", 64'(r), 64'd63);
    chk("t1_err", 64'(err), 64'd0);
    step();
    chk("t1_pulse", 64'(res_valid), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // fairness with all requesters held
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 2), 32'(i + 10));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t2_gnt%0d", k), 64'(gnt), 64'(1 << ord[k]));
      chk($sformatf("t2_a%0d", k), 64'(core_a), 64'(ord[k] + 2));
    end
    req = '0;
    for (int k = 0; k < 6; k++) begin
      wait_res($sformatf("t2_r%0d", k), rv, r, n);
      idx = ord[k];
      chk($sformatf("t2_rv%0d", k), 64'(rv), 64'(1 << idx));
      chk($sformatf("t2_res%0d", k), 64'(r), 64'((idx + 2) * (idx + 10)));
      step();
    end
    chk("t2_err", 64'(err), 64'd0);

    // same-requester guard
    do_reset();
    set_op(1, 32'd3, 32'd5);
    req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("t3_gnt%0d", k), 64'(gnt), (k % 2 == 0) ? 64'h2 : 64'h0);
    end
    req = '0;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("t3_drain", 64'(busy), 64'd0);
    chk("t3_err", 64'(err), 64'd0);

    // spurious rdy with empty pipeline
    do_reset();
    inj_rdy = 1'b1;
    step();
    inj_rdy = 1'b0;
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_resv", 64'(res_valid), 64'd0);
    repeat (3) step();
    chk("t4_sticky", 64'(err), 64'd1);

    // dropped expected rdy
    do_reset();
    drop_rdy = 1'b1;
    set_op(0, 32'd4, 32'd4);
    req = 4'b0001;
    step();
    req = '0;
    seen_v = '0;
    repeat (LAT + 3) begin
      step();
      seen_v |= res_valid;
    end
    drop_rdy = 1'b0;
    chk("t4_drop_rv", 64'(seen_v), 64'd0);
    chk("t4_drop_err", 64'(err), 64'd1);

    // reset with three ops in flight
    do_reset();
    set_op(0, 32'd2, 32'd3);
    set_op(1, 32'd4, 32'd5);
    set_op(2, 32'd6, 32'd7);
    req = 4'b0111;
    repeat (3) step();
    req = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_gnt", 64'(gnt), 64'd0);
    chk("t5_nd", 64'(core_nd), 64'd0);
    chk("t5_a", 64'(core_a), 64'd0);
    chk("t5_b", 64'(core_b), 64'd0);
    chk("t5_res", 64'(res), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    seen_v = '0;
    seen_e = 1'b0;
    repeat (2 * LAT) begin
      step();
      seen_v |= res_valid;
      seen_e |= err;
    end
    chk("t5_rv", 64'(seen_v), 64'd0);
    chk("t5_err", 64'(seen_e), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
